lfsr_f2_chk: RTL
================

Name: lfsr_f2_chk

Overview:
- Receive-side checker for the 2-tap Fibonacci XNOR LFSR pseudo-noise stream, e.g. the generator's nout[0] looped back through a DUT or link.
- Synchronises a local reference LFSR to the incoming serial bits, then compares every subsequent bit against the prediction.
- Reports lock status, an error pulse per mismatch, and bit and error totals for BER measurement.

Parameters:
- MSB, 15: LFSR length in bits; must match the generator.
- TAP2, 14: second feedback tap; must match the generator.
- LOCK_CNT, 32: consecutive correct predictions required to declare lock (≥1).
- WIN, 64: loss-of-lock observation window, in valid bits.
- LOSS_THR, 8: errors within one window that force loss of lock (1..WIN).
- CNT_W, 32: width of bit_cnt and err_cnt.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  received PRBS bit.
- din_valid  in  1  din is sampled only when high; low cycles leave all state frozen.
- clear  in  1  synchronous clear of bit_cnt and err_cnt.
- locked  out  1  checker synchronised.
- err  out  1  one-cycle pulse per mismatched bit while locked.
- bit_cnt  out  CNT_W  valid bits checked while locked.
- err_cnt  out  CNT_W  mismatches while locked.

Behaviour:
- Reset (async, rst_n low) state:
  - state=HUNT; shift register s=0; fill, match, window and window-error counters=0.
  - locked=0, err=0, bit_cnt=0, err_cnt=0.
- Prediction: s[0] is the most recent bit and s[k] is the bit k+1 valid samples ago. pred = s[TAP2-1] XNOR s[MSB-1].
- All outputs are registered and update on the edge that samples the valid bit. err defaults to 0 every cycle.
- HUNT state (each valid bit):
  - din is shifted into s[0]; s shifts up.
  - While fill < MSB: fill increments; no comparison is made.
  - Once the register is full: if din==pred and s is not all-ones, match increments; otherwise match is cleared to 0.
  - The all-ones exclusion prevents a stuck-at-1 line from locking. Stuck-at-0 mismatches naturally.
  - When match reaches LOCK_CNT: go to LOCKED, set locked=1, clear window counters.
  - Clean stream: locked rises on the edge sampling valid bit MSB+LOCK_CNT (47 with defaults).
- LOCKED state (each valid bit):
  - s shifts in pred, not din. The reference free-runs, so a single channel bit error is counted once, not multiplied by the taps.
  - bit_cnt increments.
  - If din != pred: err=1 and err_cnt increments.
  - Window counter increments; the window-error counter increments on a mismatch.
  - If the window-error count reaches LOSS_THR: next state HUNT, locked=0, fill=match=0. Counters and the current err pulse still update on that edge.
  - When the window counter reaches WIN without hitting the threshold, both window counters clear.
- Counters:
  - bit_cnt and err_cnt saturate at all-ones and never wrap.
  - Counting occurs only in LOCKED; HUNT bits are not counted.
- clear:
  - Zeros bit_cnt and err_cnt. Takes priority over any increment in the same cycle.
  - Does not affect state, s, locked or the window counters.
- din_valid=0: no shift, no count, err=0, state held.
- Reset asserted mid-operation returns to the reset state immediately, regardless of clk.
- A generator running with any INIT other than the all-ones lockup state must lock.

Test Plan:
- Generator (MSB=15, TAP2=14, INIT=1) nout[0] → din with din_valid=1:
  - locked=0 through valid bit 46; locked=1 after bit 47.
  - 1000 further bits → bit_cnt=1000, err_cnt=0, err never high.
- While locked, invert exactly one bit → exactly one err pulse, on the edge sampling that bit; err_cnt=1; locked stays 1.
- While locked, invert 8 bits within 64 → locked falls on the edge of the 8th error; err_cnt=8. Clean stream afterwards → relock after a further 47 bits.
- din held at 1, then separately held at 0, for 10000 cycles → locked stays 0; bit_cnt=err_cnt=0.
- din_valid toggled pseudo-randomly on a clean stream → lock after exactly 47 valid bits; bit_cnt equals the number of valid bits after lock.
- Remaining cases:
  - clear asserted on the same cycle as an error → counters read 0, err still pulses.
  - CNT_W=4 with 20 errors → err_cnt=15 (saturated).
  - rst_n pulsed low mid-lock → all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr_f2_chk.sv
// lfsr_f2_chk: receive-side checker for a 2-tap Fibonacci XNOR PRBS stream.
// A local reference LFSR is seeded from the incoming bits while hunting.
// Once LOCK_CNT consecutive predictions agree, the reference free-runs and
// every further valid bit is compared against it. Bit and error totals
// feed BER measurement. Lock is dropped when LOSS_THR errors land inside
// one WIN-bit observation window.
module lfsr_f2_chk #(
    parameter int MSB      = 15,
    parameter int TAP2     = 14,
    parameter int LOCK_CNT = 32,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W  = $clog2(MSB + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(MSB);
    localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [WIN_W-1:0]   WIN_END    = WIN_W'(WIN);
    localparam logic [WIN_W-1:0]   LOSS_LIM   = WIN_W'(LOSS_THR);
    localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t             state_q,   state_d;
    logic [MSB-1:0]     s_q,       s_d;
    logic [FILL_W-1:0]  fill_q,    fill_d;
    logic [MATCH_W-1:0] match_q,   match_d;
    logic [WIN_W-1:0]   win_q,     win_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic               locked_q,  locked_d;
    logic               err_q,     err_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               pred_s;
    logic               mismatch_s;
    logic               s_all_ones_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic [WIN_W-1:0]   win_inc_s;
    logic [WIN_W-1:0]   win_err_inc_s;

    // s[0] is the newest bit, s[k] the bit k+1 samples back.
    assign pred_s        = ~(s_q[TAP2-1] ^ s_q[MSB-1]);
    assign mismatch_s    = din ^ pred_s;
    // All-ones is the XNOR lockup state; a stuck-at-1 line would otherwise
    // predict itself perfectly and lock.
    assign s_all_ones_s  = &s_q;
    assign match_inc_s   = match_q + MATCH_ONE;
    assign win_inc_s     = win_q + WIN_ONE;
    assign win_err_inc_s = mismatch_s ? (win_err_q + WIN_ONE) : win_err_q;

    // Next-state logic for the hunt/locked machine, window and totals.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        win_err_d = win_err_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Seed the reference from the line itself.
                    s_d = {s_q[MSB-2:0], din};
                    if (fill_q < FILL_FULL) begin
                        fill_d = fill_q + FILL_ONE;
                    end else if (!mismatch_s && !s_all_ones_s) begin
                        match_d = match_inc_s;
                        if (match_inc_s == MATCH_LOCK) begin
                            state_d   = ST_LOCKED;
                            locked_d  = 1'b1;
                            win_d     = {WIN_W{1'b0}};
                            win_err_d = {WIN_W{1'b0}};
                        end else begin
                            locked_d = 1'b0;
                        end
                    end else begin
                        match_d = {MATCH_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so one line error is
                    // counted once rather than echoed through the taps.
                    s_d       = {s_q[MSB-2:0], pred_s};
                    bit_cnt_d = sat_inc(bit_cnt_q);
                    if (mismatch_s) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        err_d = 1'b0;
                    end
                    if (win_err_inc_s == LOSS_LIM) begin
                        state_d   = ST_HUNT;
                        locked_d  = 1'b0;
                        fill_d    = {FILL_W{1'b0}};
                        match_d   = {MATCH_W{1'b0}};
                        win_d     = {WIN_W{1'b0}};
                        win_err_d = {WIN_W{1'b0}};
                    end else if (win_inc_s == WIN_END) begin
                        win_d     = {WIN_W{1'b0}};
                        win_err_d = {WIN_W{1'b0}};
                    end else begin
                        win_d     = win_inc_s;
                        win_err_d = win_err_inc_s;
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    locked_d = 1'b0;
                    fill_d   = {FILL_W{1'b0}};
                    match_d  = {MATCH_W{1'b0}};
                end
            endcase
        end else begin
            // Idle cycle: everything holds, err already defaults low.
            state_d = state_q;
        end

        // Clear wins over any increment computed above.
        if (clear) begin
            bit_cnt_d = {CNT_W{1'b0}};
            err_cnt_d = {CNT_W{1'b0}};
        end else begin
            bit_cnt_d = bit_cnt_d;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            s_q       <= {MSB{1'b0}};
            fill_q    <= {FILL_W{1'b0}};
            match_q   <= {MATCH_W{1'b0}};
            win_q     <= {WIN_W{1'b0}};
            win_err_q <= {WIN_W{1'b0}};
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            bit_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            win_err_q <= win_err_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign bit_cnt = bit_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule
